// File: rtl/fproc_arbiter.sv
// fproc_arbiter: shares one function processor between N_CORES requesting cores.
//
// Each core posts a one-cycle request (core_enable[k] with core_id[k]). Requests are
// held as pending until served. A round-robin arbiter picks one pending core, issues its
// id to the function processor, waits for fp_ready (or a timeout), and returns the
// result to that core with a one-cycle core_ready pulse.
//
// Ports:
//   clk, reset                - clock; asynchronous active-high reset
//   core_id, core_enable      - per-core request id (core k at [k*W +: W]) and request pulse
//   core_ready, core_data     - per-core completion pulse; shared result bus
//   fp_id, fp_enable          - id and issue strobe towards the function processor
//   fp_ready, fp_data         - completion strobe and result from the function processor
//   busy                      - arbiter not idle
//   err_dup, err_timeout      - sticky: request dropped / WAIT timed out
// All outputs are registered.
module fproc_arbiter #(
  parameter int unsigned N_CORES            = 4,
  parameter int unsigned FPROC_ID_WIDTH     = 8,
  parameter int unsigned FPROC_RESULT_WIDTH = 32,
  parameter int unsigned TIMEOUT_CYCLES     = 1024
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [N_CORES*FPROC_ID_WIDTH-1:0]   core_id,
  input  logic [N_CORES-1:0]                  core_enable,
  output logic [N_CORES-1:0]                  core_ready,
  output logic [FPROC_RESULT_WIDTH-1:0]       core_data,
  output logic [FPROC_ID_WIDTH-1:0]           fp_id,
  output logic                                fp_enable,
  input  logic                                fp_ready,
  input  logic [FPROC_RESULT_WIDTH-1:0]       fp_data,
  output logic                                busy,
  output logic                                err_dup,
  output logic                                err_timeout
);

  localparam int unsigned GW  = (N_CORES > 1) ? $clog2(N_CORES) : 1;
  localparam int unsigned GW1 = GW + 1;
  localparam int unsigned CW  = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

  state_e                                       state_q, state_d;
  logic [N_CORES-1:0]                           pending_q, pending_d;
  logic [N_CORES-1:0][FPROC_ID_WIDTH-1:0]       req_id_q, req_id_d;
  logic [GW-1:0]                                grant_q, grant_d;
  logic [GW-1:0]                                last_q, last_d;
  logic [CW-1:0]                                cnt_q, cnt_d;
  logic [N_CORES-1:0]                           core_ready_q, core_ready_d;
  logic [FPROC_RESULT_WIDTH-1:0]                core_data_q, core_data_d;
  logic [FPROC_ID_WIDTH-1:0]                    fp_id_q, fp_id_d;
  logic                                         fp_enable_q, fp_enable_d;
  logic                                         busy_q, busy_d;
  logic                                         err_dup_q, err_dup_d;
  logic                                         err_timeout_q, err_timeout_d;

  // Round-robin search: first pending core at or after last_grant+1, wrapping mod N_CORES.
  logic          rr_found;
  logic [GW-1:0] rr_sel;
  logic [GW1-1:0] rr_sum;

  always_comb begin
    rr_found = 1'b0;
    rr_sel   = '0;
    rr_sum   = '0;
    for (int unsigned i = 0; i < N_CORES; i++) begin
      rr_sum = {1'b0, last_q} + GW1'(1) + GW1'(i);
      if (rr_sum >= GW1'(N_CORES)) begin
        rr_sum = rr_sum - GW1'(N_CORES);
      end
      if (!rr_found && pending_q[rr_sum[GW-1:0]]) begin
        rr_found = 1'b1;
        rr_sel   = rr_sum[GW-1:0];
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    pending_d     = pending_q;
    req_id_d      = req_id_q;
    grant_d       = grant_q;
    last_d        = last_q;
    cnt_d         = cnt_q;
    core_ready_d  = '0;
    core_data_d   = core_data_q;
    fp_id_d       = fp_id_q;
    fp_enable_d   = 1'b0;
    err_dup_d     = err_dup_q;
    err_timeout_d = err_timeout_q;

    unique case (state_q)
      StIdle: begin
        if (rr_found) begin
          grant_d     = rr_sel;
          fp_id_d     = req_id_q[rr_sel];
          fp_enable_d = 1'b1;
          state_d     = StIssue;
        end
      end
      StIssue: begin
        cnt_d   = '0;
        state_d = StWait;
      end
      StWait: begin
        // fp_ready takes priority over a timeout landing in the same cycle.
        if (fp_ready) begin
          core_data_d           = fp_data;
          core_ready_d[grant_q] = 1'b1;
          state_d               = StDone;
        end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          core_data_d           = '1;
          err_timeout_d         = 1'b1;
          core_ready_d[grant_q] = 1'b1;
          state_d               = StDone;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      StDone: begin
        pending_d[grant_q] = 1'b0;
        last_d             = grant_q;
        state_d            = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Intake after the DONE clear so the served core may re-request in its DONE cycle.
    for (int unsigned k = 0; k < N_CORES; k++) begin
      if (core_enable[k]) begin
        if (pending_d[k]) begin
          err_dup_d = 1'b1;
        end else begin
          pending_d[k] = 1'b1;
          req_id_d[k]  = core_id[k*FPROC_ID_WIDTH +: FPROC_ID_WIDTH];
        end
      end
    end

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      pending_q     <= '0;
      req_id_q      <= '0;
      grant_q       <= '0;
      last_q        <= GW'(N_CORES - 1);
      cnt_q         <= '0;
      core_ready_q  <= '0;
      core_data_q   <= '0;
      fp_id_q       <= '0;
      fp_enable_q   <= 1'b0;
      busy_q        <= 1'b0;
      err_dup_q     <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pending_q     <= pending_d;
      req_id_q      <= req_id_d;
      grant_q       <= grant_d;
      last_q        <= last_d;
      cnt_q         <= cnt_d;
      core_ready_q  <= core_ready_d;
      core_data_q   <= core_data_d;
      fp_id_q       <= fp_id_d;
      fp_enable_q   <= fp_enable_d;
      busy_q        <= busy_d;
      err_dup_q     <= err_dup_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  assign core_ready  = core_ready_q;
  assign core_data   = core_data_q;
  assign fp_id       = fp_id_q;
  assign fp_enable   = fp_enable_q;
  assign busy        = busy_q;
  assign err_dup     = err_dup_q;
  assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_fproc_arbiter.sv
// Testbench for fproc_arbiter (N_CORES=4, 8-bit ids, 32-bit results, TIMEOUT_CYCLES=8).
// A transaction-level reference model predicts every output each cycle; directed
// scenarios add hand-computed expectations at fixed cycle offsets.
module tb_fproc_arbiter;

  localparam int N  = 4;
  localparam int IW = 8;
  localparam int RW = 32;
  localparam int TO = 8;

  logic            clk;
  logic            reset;
  logic [N*IW-1:0] core_id;
  logic [N-1:0]    core_enable;
  logic [N-1:0]    core_ready;
  logic [RW-1:0]   core_data;
  logic [IW-1:0]   fp_id;
  logic            fp_enable;
  logic            fp_ready;
  logic [RW-1:0]   fp_data;
  logic            busy;
  logic            err_dup;
  logic            err_timeout;

  fproc_arbiter #(
    .N_CORES            (N),
    .FPROC_ID_WIDTH     (IW),
    .FPROC_RESULT_WIDTH (RW),
    .TIMEOUT_CYCLES     (TO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .core_id     (core_id),
    .core_enable (core_enable),
    .core_ready  (core_ready),
    .core_data   (core_data),
    .fp_id       (fp_id),
    .fp_enable   (fp_enable),
    .fp_ready    (fp_ready),
    .fp_data     (fp_data),
    .busy        (busy),
    .err_dup     (err_dup),
    .err_timeout (err_timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  bit chk_en = 1'b0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  localparam int PH_IDLE  = 0;
  localparam int PH_ISSUE = 1;
  localparam int PH_WAIT  = 2;
  localparam int PH_DONE  = 3;

  int            m_ph     = PH_IDLE;
  int            m_g      = 0;
  int            m_last   = N - 1;
  int            m_waited = 0;
  bit [N-1:0]    m_pend   = '0;
  logic [IW-1:0] m_id [N];
  logic [N-1:0]  e_ready  = '0;
  logic [RW-1:0] e_data   = '0;
  logic [IW-1:0] e_fpid   = '0;
  logic          e_fpen   = 1'b0;
  logic          e_busy   = 1'b0;
  logic          e_dup    = 1'b0;
  logic          e_to     = 1'b0;

  task automatic model_reset();
    m_ph = PH_IDLE; m_g = 0; m_last = N - 1; m_waited = 0; m_pend = '0;
    e_ready = '0; e_data = '0; e_fpid = '0; e_fpen = 1'b0;
    e_busy = 1'b0; e_dup = 1'b0; e_to = 1'b0;
  endtask

  // One clock edge: serve the transaction, then accept new requests.
  task automatic model_step();
    bit [N-1:0] pend_old;
    bit         found;
    int         c;
    bit         finish;
    pend_old = m_pend;
    found    = 1'b0;
    finish   = 1'b0;
    e_ready  = '0;
    e_fpen   = 1'b0;
    case (m_ph)
      PH_IDLE: begin
        for (int i = 1; i <= N; i++) begin
          c = (m_last + i) % N;
          if (!found && pend_old[c]) begin
            found = 1'b1;
            m_g   = c;
          end
        end
        if (found) begin
          m_ph   = PH_ISSUE;
          e_fpen = 1'b1;
          e_fpid = m_id[m_g];
        end
      end
      PH_ISSUE: begin
        m_ph     = PH_WAIT;
        m_waited = 0;
      end
      PH_WAIT: begin
        m_waited++;
        if (fp_ready) begin
          e_data = fp_data;
          finish = 1'b1;
        end else if (m_waited == TO) begin
          e_data = '1;
          e_to   = 1'b1;
          finish = 1'b1;
        end
        if (finish) begin
          m_ph       = PH_DONE;
          e_ready[m_g] = 1'b1;
        end
      end
      default: begin
        m_pend[m_g] = 1'b0;
        m_last      = m_g;
        m_ph        = PH_IDLE;
      end
    endcase
    for (int k = 0; k < N; k++) begin
      if (core_enable[k]) begin
        if (m_pend[k]) e_dup = 1'b1;
        else begin
          m_pend[k] = 1'b1;
          m_id[k]   = core_id[k*IW +: IW];
        end
      end
    end
    e_busy = (m_ph != PH_IDLE);
  endtask

  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) model_reset();
    else model_step();
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check("cmp core_ready",  64'(core_ready),  64'(e_ready));
      check("cmp core_data",   64'(core_data),   64'(e_data));
      check("cmp fp_id",       64'(fp_id),       64'(e_fpid));
      check("cmp fp_enable",   64'(fp_enable),   64'(e_fpen));
      check("cmp busy",        64'(busy),        64'(e_busy));
      check("cmp err_dup",     64'(err_dup),     64'(e_dup));
      check("cmp err_timeout", 64'(err_timeout), 64'(e_to));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic goto_cyc(input int c);
    while (cyc < c) tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    core_enable = '0;
    fp_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic wait_issue(input string name, output int at);
    at = -1;
    for (int n = 0; n < 40 && at < 0; n++) begin
      @(negedge clk);
      if (fp_enable === 1'b1) at = cyc;
    end
    if (at < 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: got no fp_enable in 40 cycles, expected an issue", name);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got simulation still running, expected $finish");
    $fatal(1);
  end

  int c0, at, prev_at, r, n_iss, n_rdy;
  int           rr_core [5] = '{0, 1, 2, 3, 0};
  logic [IW-1:0] rr_id  [5] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h20};

  initial begin
    reset = 1'b1;
    core_id = '0;
    core_enable = '0;
    fp_ready = 1'b0;
    fp_data = '0;
    tick();
    chk_en = 1'b1;
    @(negedge clk);
    check("reset outputs", {core_ready, fp_enable, busy, err_dup, err_timeout}, 64'd0);
    check("reset data", {core_data, fp_id}, 64'd0);

    // Single request: enable c0 -> issue c0+2; fp_ready c0+10 -> core_ready c0+11.
    do_reset();
    c0 = cyc;
    core_id[2*IW +: IW] = 8'h15;
    core_enable = 4'b0100;
    tick();
    core_enable = '0;
    goto_cyc(c0 + 2);
    @(negedge clk);
    check("s1 fp_enable", 64'(fp_enable), 64'd1);
    check("s1 fp_id", 64'(fp_id), 64'h15);
    goto_cyc(c0 + 10);
    fp_ready = 1'b1;
    fp_data = 32'hDEADBEEF;
    tick();
    fp_ready = 1'b0;
    fp_data = '0;
    @(negedge clk);
    check("s1 core_ready", 64'(core_ready), 64'b0100);
    check("s1 core_data", 64'(core_data), 64'hDEADBEEF);

    // Round robin: all four request together, core 0 re-requests after its completion.
    do_reset();
    for (int k = 0; k < N; k++) core_id[k*IW +: IW] = 8'(8'h10 + k);
    core_enable = 4'b1111;
    tick();
    core_enable = '0;
    prev_at = -1;
    for (int j = 0; j < 5; j++) begin
      wait_issue("s2 issue", at);
      check("s2 fp_id", 64'(fp_id), 64'(rr_id[j]));
      if (j > 0) check("s2 issue spacing", 64'(at - prev_at), 64'd6);
      prev_at = at;
      r = at + 3;
      goto_cyc(r);
      fp_ready = 1'b1;
      fp_data = 32'hA0000000 + 32'(j);
      tick();
      fp_ready = 1'b0;
      @(negedge clk);
      check("s2 core_ready", 64'(core_ready), 64'(4'b0001 << rr_core[j]));
      check("s2 core_data", 64'(core_data), 64'(32'hA0000000 + 32'(j)));
      if (j == 0) begin
        goto_cyc(at + 5);
        core_id[0 +: IW] = 8'h20;
        core_enable = 4'b0001;
        tick();
        core_enable = '0;
      end
    end

    // Duplicate: second enable from core 1 while pending is dropped.
    do_reset();
    c0 = cyc;
    core_id[1*IW +: IW] = 8'h07;
    core_enable = 4'b0010;
    tick();
    core_id[1*IW +: IW] = 8'h09;
    core_enable = 4'b0010;
    tick();
    core_enable = '0;
    @(negedge clk);
    check("s3 fp_enable", 64'(fp_enable), 64'd1);
    check("s3 fp_id", 64'(fp_id), 64'h07);
    check("s3 err_dup", 64'(err_dup), 64'd1);
    goto_cyc(c0 + 4);
    fp_ready = 1'b1;
    fp_data = 32'h00000707;
    tick();
    fp_ready = 1'b0;
    @(negedge clk);
    check("s3 core_ready", 64'(core_ready), 64'b0010);
    n_iss = 0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (fp_enable === 1'b1) n_iss++;
    end
    check("s3 extra issues", 64'(n_iss), 64'd0);
    check("s3 err_dup sticky", 64'(err_dup), 64'd1);

    // Timeout: no fp_ready -> core_ready 9 cycles after the issue with all-ones data.
    do_reset();
    c0 = cyc;
    core_id[3*IW +: IW] = 8'h33;
    core_enable = 4'b1000;
    tick();
    core_enable = '0;
    at = c0 + 2;
    goto_cyc(at + 8);
    @(negedge clk);
    check("s4 no ready before timeout", 64'(core_ready), 64'd0);
    check("s4 err_timeout early", 64'(err_timeout), 64'd0);
    goto_cyc(at + 9);
    @(negedge clk);
    check("s4 core_ready", 64'(core_ready), 64'b1000);
    check("s4 core_data", 64'(core_data), 64'hFFFFFFFF);
    check("s4 err_timeout", 64'(err_timeout), 64'd1);
    goto_cyc(at + 10);
    fp_ready = 1'b1;
    fp_data = 32'h12345678;
    tick();
    fp_ready = 1'b0;
    @(negedge clk);
    check("s4 late ready ignored", 64'(core_ready), 64'd0);
    check("s4 data held", 64'(core_data), 64'hFFFFFFFF);
    check("s4 idle", 64'(busy), 64'd0);

    // Reset in WAIT: everything clears, late fp_ready ignored, next request served.
    do_reset();
    c0 = cyc;
    core_id[0 +: IW] = 8'h44;
    core_enable = 4'b0001;
    tick();
    core_enable = '0;
    goto_cyc(c0 + 2 + 5);
    reset = 1'b1;
    #1;
    check("s5 async clear", {core_ready, fp_enable, busy, err_dup, err_timeout}, 64'd0);
    check("s5 async clear data", {core_data, fp_id}, 64'd0);
    tick();
    reset = 1'b0;
    fp_ready = 1'b1;
    fp_data = 32'h55AA55AA;
    tick();
    fp_ready = 1'b0;
    n_rdy = 0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (core_ready !== 4'b0000) n_rdy++;
    end
    check("s5 no core_ready", 64'(n_rdy), 64'd0);
    tick();
    c0 = cyc;
    core_id[1*IW +: IW] = 8'h55;
    core_enable = 4'b0010;
    tick();
    core_enable = '0;
    goto_cyc(c0 + 2);
    @(negedge clk);
    check("s5 reissue fp_enable", 64'(fp_enable), 64'd1);
    check("s5 reissue fp_id", 64'(fp_id), 64'h55);
    goto_cyc(c0 + 4);
    fp_ready = 1'b1;
    fp_data = 32'h00005555;
    tick();
    fp_ready = 1'b0;
    @(negedge clk);
    check("s5 core_ready", 64'(core_ready), 64'b0010);

    // Re-request in the DONE cycle is accepted without err_dup.
    do_reset();
    c0 = cyc;
    core_id[2*IW +: IW] = 8'h61;
    core_enable = 4'b0100;
    tick();
    core_enable = '0;
    at = c0 + 2;
    goto_cyc(at + 2);
    fp_ready = 1'b1;
    fp_data = 32'h00006161;
    tick();
    fp_ready = 1'b0;
    core_id[2*IW +: IW] = 8'h62;
    core_enable = 4'b0100;
    @(negedge clk);
    check("s6 core_ready in done", 64'(core_ready), 64'b0100);
    tick();
    core_enable = '0;
    goto_cyc(at + 5);
    @(negedge clk);
    check("s6 reissue fp_enable", 64'(fp_enable), 64'd1);
    check("s6 reissue fp_id", 64'(fp_id), 64'h62);
    check("s6 err_dup", 64'(err_dup), 64'd0);
    goto_cyc(at + 7);
    fp_ready = 1'b1;
    fp_data = 32'h00006262;
    tick();
    fp_ready = 1'b0;
    @(negedge clk);
    check("s6 core_ready", 64'(core_ready), 64'b0100);
    check("s6 core_data", 64'(core_data), 64'h00006262);

    tick();
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
